raster_tile_scheduler: RTL and testbench

- Sequences the rasterizer across a multi-tile frame.
- Buffers one frame's triangle list, then replays the whole list once per tile, tile by tile.
- Tracks per-triangle completion via the rasterizer's final-pixel handshake and emits tile/frame boundary pulses for the framebuffer writer.
- Sits between the geometry stage (upstream) and the rasterizer's triangle input (downstream).

---
 rtl/raster_tile_scheduler_pkg.sv | 19 +
 rtl/raster_tile_scheduler_store.sv | 28 ++
 rtl/raster_tile_scheduler.sv | 151 +++++++++++++++
 tb/tb_raster_tile_scheduler.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/raster_tile_scheduler_pkg.sv
// Shared types for the raster tile scheduler: triangle word, tile coordinate
// and the scheduler state encoding.
package raster_tile_scheduler_pkg;

    typedef logic [31:0] triangle_t;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
    } tile_coord_t;

    typedef enum logic [1:0] {
        LOAD     = 2'd0,
        ISSUE    = 2'd1,
        DRAIN    = 2'd2,
        TILE_END = 2'd3
    } scheduler_state_t;

endpackage

// File: rtl/raster_tile_scheduler_store.sv
// Triangle store: register array with one write port and a combinational read
// port, so the replayed triangle is available in the same cycle rd_addr moves.
module raster_tile_scheduler_store
    import raster_tile_scheduler_pkg::*;
#(
    parameter int DEPTH = 32,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  triangle_t     wr_data,
    input  logic [AW-1:0] rd_addr,
    output triangle_t     rd_data
);

    triangle_t mem [DEPTH];

    // Contents are never reset; the scheduler's count defines what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/raster_tile_scheduler.sv
// Buffers one frame of triangles, then replays the list once per tile and
// reports tile/frame boundaries once every issued triangle has finished.
//
// state    | meaning
// LOAD     | accepting the frame's triangle list from geometry
// ISSUE    | replaying store[rd_ptr] to the rasterizer for the current tile
// DRAIN    | waiting for outstanding triangles to finish rasterizing
// TILE_END | one-cycle boundary: tile_done (and frame_done on the last tile)
module raster_tile_scheduler
    import raster_tile_scheduler_pkg::*;
#(
    parameter int MAX_TRIANGLES = 32,
    parameter int TILES_X       = 5,
    parameter int TILES_Y       = 4
) (
    input  logic       clk,
    input  logic       rstn,
    output logic       triangle_s_ready,
    input  logic       triangle_s_valid,
    input  triangle_t  triangle_s_data,
    input  logic       triangle_s_last,
    input  logic       triangle_m_ready,
    output logic       triangle_m_valid,
    output triangle_t  triangle_m_data,
    output logic [7:0] tile_x,
    output logic [7:0] tile_y,
    input  logic       pixel_done,
    output logic       tile_done,
    output logic       frame_done,
    output logic       overflow
);

    localparam int AW = $clog2(MAX_TRIANGLES);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] MAX_COUNT = CW'(MAX_TRIANGLES);
    localparam logic [CW-1:0] ONE       = CW'(1);
    localparam logic [7:0]    LAST_X    = 8'(TILES_X - 1);
    localparam logic [7:0]    LAST_Y    = 8'(TILES_Y - 1);

    scheduler_state_t state;
    logic [CW-1:0]    count;
    logic [CW-1:0]    rd_ptr;
    logic [CW-1:0]    outstanding;
    tile_coord_t      tile;

    logic s_hs;
    logic m_hs;
    logic store_wr;

    assign s_hs     = triangle_s_valid & triangle_s_ready;
    assign m_hs     = triangle_m_valid & triangle_m_ready;
    assign store_wr = s_hs & (count != MAX_COUNT);

    raster_tile_scheduler_store #(
        .DEPTH (MAX_TRIANGLES)
    ) u_store (
        .clk     (clk),
        .wr_en   (store_wr),
        .wr_addr (count[AW-1:0]),
        .wr_data (triangle_s_data),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (triangle_m_data)
    );

    assign tile_x = tile.x;
    assign tile_y = tile.y;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state            <= LOAD;
            count            <= '0;
            rd_ptr           <= '0;
            outstanding      <= '0;
            tile             <= '0;
            overflow         <= 1'b0;
            triangle_s_ready <= 1'b1;
            triangle_m_valid <= 1'b0;
            tile_done        <= 1'b0;
            frame_done       <= 1'b0;
        end else begin
            tile_done  <= 1'b0;
            frame_done <= 1'b0;

            // An issue and a completion in the same cycle cancel out.
            if (m_hs && !pixel_done) begin
                outstanding <= outstanding + ONE;
            end else if (!m_hs && pixel_done && outstanding != '0) begin
                outstanding <= outstanding - ONE;
            end

            case (state)
                LOAD: begin
                    if (s_hs) begin
                        if (count != MAX_COUNT) begin
                            count <= count + ONE;
                        end else begin
                            overflow <= 1'b1;
                        end
                        if (triangle_s_last) begin
                            state            <= ISSUE;
                            rd_ptr           <= '0;
                            tile             <= '0;
                            triangle_s_ready <= 1'b0;
                            triangle_m_valid <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (triangle_m_ready) begin
                        rd_ptr <= rd_ptr + ONE;
                        if (rd_ptr + ONE == count) begin
                            state            <= DRAIN;
                            triangle_m_valid <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (outstanding == '0) begin
                        state      <= TILE_END;
                        tile_done  <= 1'b1;
                        frame_done <= (tile.x == LAST_X) && (tile.y == LAST_Y);
                    end
                end
                TILE_END: begin
                    if (tile.x != LAST_X) begin
                        tile.x           <= tile.x + 8'd1;
                        rd_ptr           <= '0;
                        state            <= ISSUE;
                        triangle_m_valid <= 1'b1;
                    end else if (tile.y != LAST_Y) begin
                        tile.x           <= 8'd0;
                        tile.y           <= tile.y + 8'd1;
                        rd_ptr           <= '0;
                        state            <= ISSUE;
                        triangle_m_valid <= 1'b1;
                    end else begin
                        count            <= '0;
                        tile             <= '0;
                        overflow         <= 1'b0;
                        state            <= LOAD;
                        triangle_s_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_raster_tile_scheduler.sv
// Self-checking bench: a table of frames is replayed through the scheduler and
// every issue and tile boundary is compared against a scoreboard.
module tb_raster_tile_scheduler;
    import raster_tile_scheduler_pkg::*;

    localparam int MAXT = 4;
    localparam int TX   = 2;
    localparam int TY   = 2;
    localparam int NT   = TX * TY;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       triangle_s_ready;
    logic       triangle_s_valid = 1'b0;
    triangle_t  triangle_s_data = '0;
    logic       triangle_s_last = 1'b0;
    logic       triangle_m_ready = 1'b1;
    logic       triangle_m_valid;
    triangle_t  triangle_m_data;
    logic [7:0] tile_x;
    logic [7:0] tile_y;
    logic       pixel_done = 1'b0;
    logic       tile_done;
    logic       frame_done;
    logic       overflow;

    always #5 clk = ~clk;

    raster_tile_scheduler #(
        .MAX_TRIANGLES (MAXT),
        .TILES_X       (TX),
        .TILES_Y       (TY)
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .triangle_s_ready (triangle_s_ready),
        .triangle_s_valid (triangle_s_valid),
        .triangle_s_data  (triangle_s_data),
        .triangle_s_last  (triangle_s_last),
        .triangle_m_ready (triangle_m_ready),
        .triangle_m_valid (triangle_m_valid),
        .triangle_m_data  (triangle_m_data),
        .tile_x           (tile_x),
        .tile_y           (tile_y),
        .pixel_done       (pixel_done),
        .tile_done        (tile_done),
        .frame_done       (frame_done),
        .overflow         (overflow)
    );

    typedef struct { triangle_t data; logic [7:0] x; logic [7:0] y; } issue_t;
    typedef struct { logic [7:0] x; logic [7:0] y; logic fin; } tile_t;
    typedef struct { int n_tri; int delay; int stall_len; int exp_issues; } vec_t;

    issue_t exp_q[$];
    tile_t  tile_q[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Rasterizer model and output monitor, sampled 1 unit after the falling edge.
    int        idx = 0, last_hs_idx = 0, last_pd_idx = 0, pd_delay = 5, model_out = 0;
    int        n_issued = 0, n_tiles = 0, n_frames = 0;
    logic [15:0] pipe = '0;
    logic      first_pending = 1'b0, prev_stall = 1'b0, spurious = 1'b0;
    logic      hs, pd_real;
    triangle_t prev_data;
    issue_t    e;
    tile_t     t;

    initial begin
        forever begin
            @(negedge clk);
            #1;
            idx++;
            if (!rstn) begin
                pipe = '0; pixel_done = 1'b0; model_out = 0;
                prev_stall = 1'b0; first_pending = 1'b0;
            end else begin
                if (triangle_s_valid && triangle_s_ready && triangle_s_last) begin
                    last_hs_idx = idx;
                    first_pending = 1'b1;
                end
                if (prev_stall) begin
                    check("stall_valid", triangle_m_valid, 1);
                    check("stall_data", triangle_m_data, prev_data);
                end
                prev_stall = triangle_m_valid && !triangle_m_ready;
                prev_data  = triangle_m_data;

                if (tile_done || frame_done) begin
                    if (tile_done) n_tiles++;
                    if (frame_done) n_frames++;
                    if (tile_q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL tile_unexpected: got tile (%0d,%0d) required none", tile_x, tile_y);
                    end else begin
                        t = tile_q.pop_front();
                        check("tile_x", tile_x, t.x);
                        check("tile_y", tile_y, t.y);
                        check("tile_done", tile_done, 1);
                        check("frame_done", frame_done, t.fin);
                    end
                    check("tile_latency", idx - last_pd_idx, 2);
                    check("tile_outstanding", model_out, 0);
                end

                hs = triangle_m_valid && triangle_m_ready;
                if (hs) begin
                    n_issued++;
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL issue_unexpected: got %0h required none", triangle_m_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("issue_data", triangle_m_data, e.data);
                        check("issue_tile_x", tile_x, e.x);
                        check("issue_tile_y", tile_y, e.y);
                    end
                    if (first_pending) begin
                        check("first_issue_latency", idx - last_hs_idx, 1);
                        first_pending = 1'b0;
                    end
                end

                pd_real = pipe[0];
                pipe = pipe >> 1;
                if (hs) begin
                    pipe[pd_delay-1] = 1'b1;
                    model_out++;
                end
                if (pd_real) begin
                    model_out--;
                    last_pd_idx = idx;
                end
                pixel_done = pd_real | spurious;
            end
        end
    end

    task automatic send_tri(input triangle_t d, input logic last);
        int b = 0;
        triangle_s_valid = 1'b1;
        triangle_s_data  = d;
        triangle_s_last  = last;
        while (!triangle_s_ready && b < 500) begin
            @(negedge clk);
            b++;
        end
        check("send_timeout", (b < 500), 1);
        @(negedge clk);
        triangle_s_valid = 1'b0;
        triangle_s_last  = 1'b0;
    endtask

    task automatic push_frame(input triangle_t tris[$], input int kept);
        for (int ty = 0; ty < TY; ty++) begin
            for (int tx = 0; tx < TX; tx++) begin
                for (int i = 0; i < kept; i++) exp_q.push_back('{tris[i], 8'(tx), 8'(ty)});
                tile_q.push_back('{8'(tx), 8'(ty), (tx == TX-1) && (ty == TY-1)});
            end
        end
    endtask

    task automatic run_frame(input vec_t v, input string tag);
        triangle_t tris[$];
        int b;
        int iss0 = n_issued;
        int til0 = n_tiles;
        int fr0  = n_frames;
        int kept = (v.n_tri < MAXT) ? v.n_tri : MAXT;
        pd_delay = v.delay;
        for (int i = 0; i < v.n_tri; i++) tris.push_back($urandom);
        push_frame(tris, kept);
        for (int i = 0; i < v.n_tri; i++) begin
            send_tri(tris[i], i == v.n_tri - 1);
            check({tag, "_overflow"}, overflow, (i >= MAXT));
        end
        if (v.stall_len > 0) begin
            b = 0;
            while (n_issued < iss0 + 1 && b < 100) begin @(negedge clk); b++; end
            check({tag, "_stall_wait"}, (b < 100), 1);
            triangle_m_ready = 1'b0;
            repeat (v.stall_len) @(negedge clk);
            triangle_m_ready = 1'b1;
        end
        b = 0;
        while (n_frames < fr0 + 1 && b < 3000) begin @(negedge clk); b++; end
        check({tag, "_frame_timeout"}, (b < 3000), 1);
        check({tag, "_issues"}, n_issued - iss0, v.exp_issues);
        check({tag, "_tiles"}, n_tiles - til0, NT);
        check({tag, "_overflow_cleared"}, overflow, 0);
        check({tag, "_back_in_load"}, triangle_s_ready, 1);
        check({tag, "_queue_drained"}, exp_q.size(), 0);
    endtask

    vec_t vecs[6];

    initial begin
        triangle_t tris[$];
        int b;
        int iss0;
        vecs[0] = '{3, 5, 0,  3 * NT};
        vecs[1] = '{3, 5, 10, 3 * NT};
        vecs[2] = '{3, 1, 0,  3 * NT};
        vecs[3] = '{6, 3, 0,  MAXT * NT};
        vecs[4] = '{1, 2, 0,  1 * NT};
        vecs[5] = '{4, 4, 0,  MAXT * NT};

        repeat (3) @(negedge clk);
        check("rst_s_ready", triangle_s_ready, 1);
        check("rst_m_valid", triangle_m_valid, 0);
        check("rst_tile_x", tile_x, 0);
        check("rst_tile_y", tile_y, 0);
        check("rst_tile_done", tile_done, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_overflow", overflow, 0);
        rstn = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 6; k++) run_frame(vecs[k], $sformatf("vec%0d", k));

        // Spurious completion while idle must not underflow the in-flight count.
        iss0 = n_tiles;
        spurious = 1'b1;
        @(negedge clk);
        spurious = 1'b0;
        repeat (6) @(negedge clk);
        check("spurious_no_tile", n_tiles - iss0, 0);
        run_frame('{3, 4, 0, 3 * NT}, "after_spurious");

        // Reset while draining tile (1,0).
        pd_delay = 5;
        iss0 = n_issued;
        tris.delete();
        for (int i = 0; i < 3; i++) tris.push_back($urandom);
        push_frame(tris, 3);
        for (int i = 0; i < 3; i++) send_tri(tris[i], i == 2);
        b = 0;
        while (n_issued < iss0 + 6 && b < 500) begin @(negedge clk); b++; end
        check("drain_wait", (b < 500), 1);
        check("drain_tile_x", tile_x, 1);
        check("drain_m_valid", triangle_m_valid, 0);
        rstn = 1'b0;
        exp_q.delete();
        tile_q.delete();
        #1;
        check("midrst_s_ready", triangle_s_ready, 1);
        check("midrst_m_valid", triangle_m_valid, 0);
        check("midrst_tile_x", tile_x, 0);
        check("midrst_tile_done", tile_done, 0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        run_frame('{2, 3, 0, 2 * NT}, "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
